// File: rtl/dram_rd_pkg.sv
// rtl/dram_rd_pkg.sv - shared constants, state encoding and tag-bundle width for the raster reader
package dram_rd_pkg;

    localparam int IMG_W_DEF      = 640;
    localparam int IMG_H_DEF      = 480;
    localparam int PIX_COUNT      = IMG_W_DEF * IMG_H_DEF;
    localparam int A_WIDTH_DEF    = 19;
    localparam int D_WIDTH_DEF    = 8;
    localparam int FIFO_DEPTH_DEF = 4;

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_READ  = 2'd1,
        S_DRAIN = 2'd2,
        S_DONE  = 2'd3
    } rd_state_e;

    // Pixel bundle carried through the FIFO: {eof, eol, sof, data}.
    function automatic int tag_width(input int d_width);
        return d_width + 3;
    endfunction

    localparam int TAG_W = tag_width(D_WIDTH_DEF);

endpackage

// File: rtl/pix_sync_fifo.sv
// rtl/pix_sync_fifo.sv - single-clock FIFO holding tagged pixels between DRAM and the stream port
module pix_sync_fifo
    import dram_rd_pkg::*;
#(
    parameter int WIDTH = TAG_W,
    parameter int DEPTH = FIFO_DEPTH_DEF
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic                       push,
    input  logic [WIDTH-1:0]           din,
    input  logic                       pop,
    output logic [WIDTH-1:0]           dout,
    output logic                       full,
    output logic                       empty,
    output logic [$clog2(DEPTH):0]     count
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [AW-1:0]    wr_ptr_q;
    logic [AW-1:0]    rd_ptr_q;
    logic [CW-1:0]    count_q;
    logic             do_push;
    logic             do_pop;

    assign full    = (count_q == CW'(DEPTH));
    assign empty   = (count_q == '0);
    assign count   = count_q;
    assign dout    = mem_q[rd_ptr_q];
    assign do_pop  = pop & ~empty;
    assign do_push = push & (~full | do_pop);

    // Storage needs no reset: the head is never observed while empty.
    always_ff @(posedge clk) begin
        if (do_push) begin
            mem_q[wr_ptr_q] <= din;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            if (do_push) begin
                wr_ptr_q <= wr_ptr_q + 1'b1;
            end
            if (do_pop) begin
                rd_ptr_q <= rd_ptr_q + 1'b1;
            end
            if (do_push && !do_pop) begin
                count_q <= count_q + 1'b1;
            end else if (do_pop && !do_push) begin
                count_q <= count_q - 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst_n) begin
            assert (!(push && full && !pop));
        end
    end

endmodule

// File: rtl/dram_raster_reader.sv
// rtl/dram_raster_reader.sv - raster-order frame reader from DRAM to a valid/ready pixel stream
module dram_raster_reader
    import dram_rd_pkg::*;
#(
    parameter int IMG_W      = IMG_W_DEF,
    parameter int IMG_H      = IMG_H_DEF,
    parameter int A_WIDTH    = A_WIDTH_DEF,
    parameter int D_WIDTH    = D_WIDTH_DEF,
    parameter int FIFO_DEPTH = FIFO_DEPTH_DEF
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               start,
    output logic               busy,
    output logic               done,
    output logic               mem_ren,
    output logic [A_WIDTH-1:0] mem_raddr,
    input  logic [D_WIDTH-1:0] mem_rdata,
    output logic               pix_valid,
    input  logic               pix_ready,
    output logic [D_WIDTH-1:0] pix_data,
    output logic               pix_sof,
    output logic               pix_eol,
    output logic               pix_eof
);

    localparam int NPIX = IMG_W * IMG_H;
    localparam int BW   = tag_width(D_WIDTH);
    localparam int CW   = $clog2(FIFO_DEPTH) + 1;
    localparam int CUW  = CW + 1;
    localparam int XW   = (IMG_W > 1) ? $clog2(IMG_W) : 1;
    localparam int YW   = (IMG_H > 1) ? $clog2(IMG_H) : 1;

    localparam logic [A_WIDTH-1:0] ADDR_LAST = A_WIDTH'(NPIX - 1);
    localparam logic [XW-1:0]      X_LAST    = XW'(IMG_W - 1);
    localparam logic [YW-1:0]      Y_LAST    = YW'(IMG_H - 1);
    localparam logic [CUW-1:0]     CREDITS   = CUW'(FIFO_DEPTH);

    rd_state_e          state_q;
    logic [A_WIDTH-1:0] addr_q;
    logic               inflight_q;
    logic [XW-1:0]      x_q;
    logic [YW-1:0]      y_q;

    logic [BW-1:0]      push_data;
    logic [BW-1:0]      head;
    logic [CW-1:0]      fifo_count;
    logic               fifo_full;
    logic               fifo_empty;
    logic               pop;
    logic [CUW-1:0]     credit_used;
    logic               tag_sof;
    logic               tag_eol;
    logic               tag_eof;

    assign pop         = pix_valid & pix_ready;
    // Entries held plus the read still in flight, minus the one leaving this cycle.
    assign credit_used = CUW'(fifo_count) + CUW'(inflight_q) - CUW'(pop);
    assign mem_ren     = (state_q == S_READ) && (credit_used < CREDITS);
    assign mem_raddr   = addr_q;

    assign tag_sof   = (x_q == '0) && (y_q == '0);
    assign tag_eol   = (x_q == X_LAST);
    assign tag_eof   = tag_eol && (y_q == Y_LAST);
    assign push_data = {tag_eof, tag_eol, tag_sof, mem_rdata};

    assign pix_valid = ~fifo_empty;
    assign pix_data  = pix_valid ? head[D_WIDTH-1:0] : '0;
    assign pix_sof   = pix_valid & head[D_WIDTH];
    assign pix_eol   = pix_valid & head[D_WIDTH+1];
    assign pix_eof   = pix_valid & head[D_WIDTH+2];

    assign busy = (state_q != S_IDLE);
    assign done = (state_q == S_DONE);

    pix_sync_fifo #(
        .WIDTH (BW),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk   (clk),
        .rst_n (rst_n),
        .push  (inflight_q),
        .din   (push_data),
        .pop   (pop),
        .dout  (head),
        .full  (fifo_full),
        .empty (fifo_empty),
        .count (fifo_count)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= S_IDLE;
            addr_q     <= '0;
            inflight_q <= 1'b0;
            x_q        <= '0;
            y_q        <= '0;
        end else begin
            inflight_q <= mem_ren;
            if (mem_ren) begin
                addr_q <= addr_q + 1'b1;
            end
            // x/y trail the address by one cycle so tags line up with returning data.
            if (inflight_q) begin
                if (x_q == X_LAST) begin
                    x_q <= '0;
                    y_q <= (y_q == Y_LAST) ? '0 : y_q + 1'b1;
                end else begin
                    x_q <= x_q + 1'b1;
                end
            end
            case (state_q)
                S_IDLE: begin
                    if (start) begin
                        state_q <= S_READ;
                        addr_q  <= '0;
                        x_q     <= '0;
                        y_q     <= '0;
                    end
                end
                S_READ: begin
                    if (mem_ren && addr_q == ADDR_LAST) begin
                        state_q <= S_DRAIN;
                    end
                end
                S_DRAIN: begin
                    if (pop && pix_eof && !inflight_q && fifo_count == CW'(1)) begin
                        state_q <= S_DONE;
                    end
                end
                S_DONE: begin
                    state_q <= S_IDLE;
                end
                default: state_q <= S_IDLE;
            endcase
        end
    end

    logic unused_ok;
    assign unused_ok = fifo_full;

endmodule
